// File: rtl/effects_chain_sequencer_pkg.sv
// Shared types and helpers for the effects chain sequencer: FSM states, default
// parameters, watchdog counter sizing and the saturating statistics increment.
package effects_chain_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_OUTPUT
   } state_t;

   localparam int DEF_WIDTH      = 12;
   localparam int DEF_NUM_STAGES = 4;
   localparam int DEF_TIMEOUT    = 48;
   localparam int STAT_W         = 8;

   // Watchdog counter must be able to hold the value TIMEOUT itself.
   function automatic int timer_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value,
                                                 input logic              inc);
      return (inc && (value != '1)) ? value + 1'b1 : value;
   endfunction

endpackage

// File: rtl/fx_stage_watchdog.sv
// Per-stage wait timer: clear restarts the count, enable advances it while a
// stage is pending, and expired rises once TIMEOUT wait cycles have elapsed.
module fx_stage_watchdog
   import effects_chain_sequencer_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = timer_width(TIMEOUT);

   logic [CNT_W-1:0] count;

   // Clear loads 1 so that count equals the number of the current wait cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= CNT_W'(1);
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count >= CNT_W'(TIMEOUT));

endmodule

// File: rtl/effects_chain_sequencer.sv
// Sequences one sample per ready strobe through NUM_STAGES start/done effect stages,
// with per-stage bypass, timeout skip and sticky error flags. Build option FX_SEQ_STATS_EN.
module effects_chain_sequencer
   import effects_chain_sequencer_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        ready,
   input  logic [WIDTH-1:0]            sample_in,
   input  logic [NUM_STAGES-1:0]       bypass_mask,
   input  logic                        err_clear,
   output logic [NUM_STAGES-1:0]       stage_start,
   output logic [WIDTH-1:0]            stage_in,
   input  logic [NUM_STAGES*WIDTH-1:0] stage_out,
   input  logic [NUM_STAGES-1:0]       stage_done,
   output logic [WIDTH-1:0]            sample_out,
   output logic                        sample_valid,
   output logic                        busy,
   output logic                        overrun,
`ifdef FX_SEQ_STATS_EN
   output logic [STAT_W-1:0]           timeout_count,
   output logic [STAT_W-1:0]           drop_count,
`endif
   output logic                        timeout_err
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [WIDTH-1:0]  acc;
   logic [NUM_STAGES-1:0] mask;

   logic expired;
   logic first_wait;
   logic done_hit;
   logic timeout_hit;
   logic drop_hit;
   logic advance;
   logic [WIDTH-1:0] next_acc;

   // The start pulse only exists in the first wait cycle, so it doubles as that marker.
   assign first_wait  = |stage_start;
   assign done_hit    = (state == S_WAIT) && !first_wait && stage_done[idx];
   assign timeout_hit = (state == S_WAIT) && expired && !done_hit;
   assign drop_hit    = ready && (state != S_IDLE);
   assign advance     = ((state == S_LAUNCH) && mask[idx]) || done_hit || timeout_hit;
   assign next_acc    = done_hit ? stage_out[int'(idx)*WIDTH +: WIDTH] : acc;
   assign busy        = (state != S_IDLE);

   fx_stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (state == S_LAUNCH),
      .enable  (state == S_WAIT),
      .expired (expired)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         idx          <= '0;
         acc          <= '0;
         mask         <= '0;
         stage_start  <= '0;
         stage_in     <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low here; later assignments in this block win.
         stage_start  <= '0;
         sample_valid <= 1'b0;
         overrun      <= (overrun & ~err_clear) | drop_hit;
         timeout_err  <= (timeout_err & ~err_clear) | timeout_hit;

         case (state)
            S_IDLE: begin
               if (ready) begin
                  acc   <= sample_in;
                  mask  <= bypass_mask;
                  idx   <= '0;
                  state <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (!mask[idx]) begin
                  state       <= S_WAIT;
                  stage_start <= NUM_STAGES'(1) << idx;
                  stage_in    <= acc;
               end
            end
            S_WAIT:   acc   <= next_acc;
            S_OUTPUT: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase

         if (advance) begin
            if (idx == LAST_IDX) begin
               state        <= S_OUTPUT;
               sample_out   <= next_acc;
               sample_valid <= 1'b1;
            end else begin
               idx   <= idx + 1'b1;
               state <= S_LAUNCH;
            end
         end
      end
   end

`ifdef FX_SEQ_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         timeout_count <= '0;
         drop_count    <= '0;
      end else begin
         timeout_count <= sat_inc(err_clear ? STAT_W'(0) : timeout_count, timeout_hit);
         drop_count    <= sat_inc(err_clear ? STAT_W'(0) : drop_count, drop_hit);
      end
   end
`endif

endmodule
